// File: rtl/inv_sub_bytes_shft_rows_seq_pkg.sv
// Shared AES state geometry, FSM encoding and the InvShiftRows wiring helper
// for the iterative InvSubBytes/InvShiftRows engine.
package inv_sub_bytes_shft_rows_seq_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_NB      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // LSB offset of byte (row, col); byte 0 sits in the top bits (column-major).
  function automatic int byte_off(input int row, input int col);
    return AES_STATE_W - 8 - 8 * (AES_NB * col + row);
  endfunction

  function automatic logic [AES_STATE_W-1:0] inv_shift_rows(input logic [AES_STATE_W-1:0] s);
    logic [AES_STATE_W-1:0] r;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < AES_NB; col++) begin
        r[byte_off(row, col) +: 8] = s[byte_off(row, (col - row + AES_NB) % AES_NB) +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_shft_rows_seq_inv_sbox.sv
// Combinational FIPS-197 inverse S-box: one byte in, one byte out.
module inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_o = INV_SBOX[in_i];

endmodule

// File: rtl/inv_sub_bytes_shft_rows_seq.sv
// Iterative InvShiftRows + InvSubBytes: BYTES_PER_CYC inverse S-boxes walk the
// state over 16/BYTES_PER_CYC cycles; valid/ready on both sides.
module inv_sub_bytes_shft_rows_seq
  import inv_sub_bytes_shft_rows_seq_pkg::*;
#(
  parameter int BYTES_PER_CYC = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] sb_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] sb_o
);

  localparam int N     = 16 / BYTES_PER_CYC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int GRP_W = 8 * BYTES_PER_CYC;

  if (BYTES_PER_CYC != 4 && BYTES_PER_CYC != 8 && BYTES_PER_CYC != 16) begin : g_bad_param
    $error("BYTES_PER_CYC must be 4, 8 or 16");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] work_q, work_d;
  logic [AES_STATE_W-1:0] sb_q, sb_d;
  logic                   out_vld_q, out_vld_d;
  logic                   accept;
  logic                   last_grp;
  logic [GRP_W-1:0]       grp_in, grp_out;

  assign grp_in   = work_q[AES_STATE_W-1-GRP_W*int'(cnt_q) -: GRP_W];
  assign last_grp = (cnt_q == CNT_W'(N - 1));

  for (genvar g = 0; g < BYTES_PER_CYC; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .in_i  (grp_in[GRP_W-1-8*g -: 8]),
      .out_o (grp_out[GRP_W-1-8*g -: 8])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      sb_q      <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      sb_q      <= sb_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (last_grp) state_d = ST_DONE;
      ST_DONE: if (out_ready_i) state_d = in_valid_i ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // DONE passes downstream ready straight through so a new state can enter
  // on the same edge the result leaves.
  always_comb begin
    in_ready_o = 1'b0;
    unique case (state_q)
      ST_IDLE: in_ready_o = 1'b1;
      ST_DONE: in_ready_o = out_ready_i;
      default: in_ready_o = 1'b0;
    endcase
  end

  assign accept = in_valid_i & in_ready_o;

  always_comb begin
    work_d    = work_q;
    cnt_d     = cnt_q;
    sb_d      = sb_q;
    out_vld_d = out_vld_q;
    if (state_q == ST_DONE && out_ready_i) out_vld_d = 1'b0;
    if (accept) begin
      work_d = inv_shift_rows(sb_i);
      cnt_d  = '0;
    end else if (state_q == ST_BUSY) begin
      work_d[AES_STATE_W-1-GRP_W*int'(cnt_q) -: GRP_W] = grp_out;
      if (last_grp) begin
        sb_d      = work_d;
        out_vld_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign sb_o        = sb_q;
  assign out_valid_o = out_vld_q;

endmodule
